piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 106 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer: captures a word on accept and emits it one bit per
// clock, optionally followed by an even-parity bit, with back-to-back frame support.
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int unsigned N     = WIDTH + (PARITY_EN ? 32'd1 : 32'd0);
    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               sout_q, sout_d;
    logic               valid_q, valid_d;
    logic               start_q, start_d;
    logic               end_q, end_d;
    logic               accept;

    // Ready comes from registered state; a frame's last bit frees the slot.
    assign load_ready = !rst && ((state_q == IDLE) || (cnt_q == LAST));
    assign accept     = load_valid && load_ready;

    // Outputs are precomputed one cycle ahead so the registers show frame bit [counter].
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            par_d   = ^din;
            sout_d  = MSB_FIRST ? din[WIDTH-1] : din[0];
            shreg_d = MSB_FIRST ? (din << 1) : (din >> 1);
            valid_d = 1'b1;
            start_d = 1'b1;
            end_d   = 1'b0;
        end else if ((state_q == SHIFT) && (cnt_q != LAST)) begin
            cnt_d   = cnt_q + CNT_W'(1);
            valid_d = 1'b1;
            end_d   = (cnt_d == LAST);
            if ((32'(cnt_q) + 32'd1) < WIDTH) begin
                sout_d  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            end else begin
                sout_d  = par_q;
            end
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            par_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = valid_q;
    assign frame_start = start_q;
    assign frame_end   = end_q;

endmodule
